// File: rtl/prng_rnd_feeder_if.sv
// PRNG-side link of the random-word feeder: reseed control plus the
// valid/ready output stream of prng_top.
// master = feeder side, slave = PRNG side.
interface prng_rnd_feeder_if #(
   parameter int RND = 1160
);
   logic [79:0]    prng_seed;
   logic           prng_start_reseed;
   logic           prng_busy;
   logic           prng_out_valid;
   logic           prng_out_ready;
   logic [RND-1:0] prng_out_rnd;

   modport master (
      output prng_seed,
      output prng_start_reseed,
      output prng_out_ready,
      input  prng_busy,
      input  prng_out_valid,
      input  prng_out_rnd
   );

   modport slave (
      input  prng_seed,
      input  prng_start_reseed,
      input  prng_out_ready,
      output prng_busy,
      output prng_out_valid,
      output prng_out_rnd
   );
endinterface

// File: rtl/prng_rnd_feeder.sv
// Consumer-side controller for the prng_top output stream in masked AES builds.
// Runs the reseed handshake, buffers PRNG words in a small FIFO and hands one
// fresh word per request to the masked core. The head word comes from
// registered storage only; there is no PRNG-to-core combinational path.
// Optional feature macro: RND_FEEDER_STATS_EN adds the stall_cnt and word_cnt
// outputs. These are a stall counter and a pop counter, both saturating.
module prng_rnd_feeder #(
   parameter int RND           = 1160,
   parameter int DEPTH         = 2,
   parameter int RESEED_PERIOD = 0
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic [79:0]            seed_in,
   input  logic                   reseed_req,
   prng_rnd_feeder_if.master      prng,
   input  logic                   rnd_req,
   output logic                   rnd_valid,
   output logic [RND-1:0]         rnd,
   output logic                   reseed_done,
   output logic                   underflow
`ifdef RND_FEEDER_STATS_EN
   ,
   output logic [31:0]            stall_cnt,
   output logic [31:0]            word_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_RUN
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [31:0]     pop_cnt_q, pop_cnt_d;
   logic [79:0]     seed_q, seed_d;
   logic            done_q, done_d;
   logic            uf_q, uf_d;
   logic [RND-1:0]  mem_q [DEPTH];

   logic            in_run, full, auto_trig, trig, push, pop, busy_fell;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Handshake decode; ready depends on the registered count, never on the
   // PRNG valid, and is withheld in the cycle a reseed is triggered.
   always_comb begin
      in_run    = (state_q == ST_RUN);
      full      = (count_q == DEPTH_C);
      auto_trig = (RESEED_PERIOD != 0) && (pop_cnt_q == 32'(RESEED_PERIOD));
      trig      = in_run & (reseed_req | auto_trig);
      busy_fell = (state_q == ST_WAIT_LO) & ~prng.prng_busy;
      prng.prng_out_ready    = in_run & ~full & ~trig;
      rnd_valid              = in_run & (count_q != '0);
      push                   = prng.prng_out_valid & prng.prng_out_ready;
      pop                    = rnd_req & rnd_valid;
      prng.prng_start_reseed = (state_q == ST_START);
      prng.prng_seed         = seed_q;
      rnd                    = rnd_valid ? mem_q[rd_ptr_q] : '0;
      reseed_done            = done_q;
      underflow              = uf_q;
   end

   // Reseed sequencer: next state, seed capture on entry to START, done pulse.
   always_comb begin
      state_d = state_q;
      seed_d  = seed_q;
      done_d  = busy_fell;
      unique case (state_q)
         ST_IDLE: begin
            if (reseed_req) begin
               state_d = ST_START;
               seed_d  = seed_in;
            end
         end
         ST_START:   state_d = ST_WAIT_HI;
         ST_WAIT_HI: if (prng.prng_busy) state_d = ST_WAIT_LO;
         ST_WAIT_LO: if (!prng.prng_busy) state_d = ST_RUN;
         ST_RUN: begin
            if (trig) begin
               state_d = ST_START;
               seed_d  = seed_in;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FIFO pointers/count, pop counter and sticky underflow; a reseed flushes.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      pop_cnt_d = pop_cnt_q;
      uf_d      = uf_q | (rnd_req & ~rnd_valid);
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         pop_cnt_d = pop_cnt_q + 32'd1;
      end
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (trig) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
      if (busy_fell) pop_cnt_d = '0;
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         pop_cnt_q <= '0;
         seed_q    <= '0;
         done_q    <= 1'b0;
         uf_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         pop_cnt_q <= pop_cnt_d;
         seed_q    <= seed_d;
         done_q    <= done_d;
         uf_q      <= uf_d;
      end
   end

   // Word storage; not reset, the head is masked by rnd_valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= prng.prng_out_rnd;
   end

`ifdef RND_FEEDER_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] word_cnt_q, word_cnt_d;

   // Saturating stall and delivered-word counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      word_cnt_d  = word_cnt_q;
      if (in_run & rnd_req & ~rnd_valid) stall_cnt_d = sat_inc(stall_cnt_q);
      if (pop) word_cnt_d = sat_inc(word_cnt_q);
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         stall_cnt_q <= '0;
         word_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign word_cnt  = word_cnt_q;
`endif

endmodule

// File: tb/tb_prng_rnd_feeder.sv
// Randomized bench for prng_rnd_feeder against a queue-based reference model.
module tb_prng_rnd_feeder;
   localparam int RND    = 64;
   localparam int DEPTH  = 2;
   localparam int PERIOD = 5;

   localparam int P_IDLE    = 0;
   localparam int P_START   = 1;
   localparam int P_WAIT_HI = 2;
   localparam int P_WAIT_LO = 3;
   localparam int P_RUN     = 4;

   logic           clk = 1'b0;
   logic           nrst;
   logic [79:0]    seed_in;
   logic           reseed_req;
   logic           rnd_req;
   logic           rnd_valid;
   logic [RND-1:0] rnd;
   logic           reseed_done;
   logic           underflow;
`ifdef RND_FEEDER_STATS_EN
   logic [31:0]    stall_cnt;
   logic [31:0]    word_cnt;
`endif

   prng_rnd_feeder_if #(.RND(RND)) pif ();

   prng_rnd_feeder #(
      .RND(RND), .DEPTH(DEPTH), .RESEED_PERIOD(PERIOD)
   ) dut (
      .clk(clk),
      .nrst(nrst),
      .seed_in(seed_in),
      .reseed_req(reseed_req),
      .prng(pif),
      .rnd_req(rnd_req),
      .rnd_valid(rnd_valid),
      .rnd(rnd),
      .reseed_done(reseed_done),
      .underflow(underflow)
`ifdef RND_FEEDER_STATS_EN
      ,
      .stall_cnt(stall_cnt),
      .word_cnt(word_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int             ph;
   logic [RND-1:0] mq[$];
   int             m_pops;
   bit             m_uf;
   bit             m_done;
   logic [79:0]    m_seed;
   int             m_stall;
   int             m_words;
   int             tag;
   int             b_lo, b_hi;
   int             n_start, n_acc;

   task automatic check_val(input string tag_s, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag_s, obs, exp);
      end
   endtask

   task automatic model_reset();
      ph      = P_IDLE;
      mq.delete();
      m_pops  = 0;
      m_uf    = 0;
      m_done  = 0;
      m_seed  = '0;
      m_stall = 0;
      m_words = 0;
      b_lo    = 0;
      b_hi    = 0;
   endtask

   task automatic check_zero(input string w);
      check_val({w, "_ready"},  128'(pif.prng_out_ready), 128'(0));
      check_val({w, "_start"},  128'(pif.prng_start_reseed), 128'(0));
      check_val({w, "_seed"},   128'(pif.prng_seed), 128'(0));
      check_val({w, "_valid"},  128'(rnd_valid), 128'(0));
      check_val({w, "_rnd"},    128'(rnd), 128'(0));
      check_val({w, "_done"},   128'(reseed_done), 128'(0));
      check_val({w, "_uflow"},  128'(underflow), 128'(0));
`ifdef RND_FEEDER_STATS_EN
      check_val({w, "_stall"},  128'(stall_cnt), 128'(0));
      check_val({w, "_words"},  128'(word_cnt), 128'(0));
`endif
   endtask

   task automatic drive_word();
      pif.prng_out_rnd = {32'($urandom), 32'(tag)};
   endtask

   // One clock cycle: compare at the falling edge, then advance the model
   // with the inputs the DUT samples on the next rising edge.
   task automatic step();
      bit trig, er, ev, pop, push;
      @(negedge clk);
      trig = (ph == P_RUN) && (reseed_req || (PERIOD > 0 && m_pops >= PERIOD));
      er   = (ph == P_RUN) && (mq.size() < DEPTH) && !trig;
      ev   = (ph == P_RUN) && (mq.size() > 0);
      check_val("prng_out_ready", 128'(pif.prng_out_ready), 128'(er));
      check_val("rnd_valid", 128'(rnd_valid), 128'(ev));
      if (ev) check_val("rnd", 128'(rnd), 128'(mq[0]));
      check_val("prng_start_reseed", 128'(pif.prng_start_reseed), 128'(ph == P_START));
      check_val("prng_seed", 128'(pif.prng_seed), 128'(m_seed));
      check_val("reseed_done", 128'(reseed_done), 128'(m_done));
      check_val("underflow", 128'(underflow), 128'(m_uf));
`ifdef RND_FEEDER_STATS_EN
      check_val("stall_cnt", 128'(stall_cnt), 128'(m_stall));
      check_val("word_cnt", 128'(word_cnt), 128'(m_words));
`endif
      if (pif.prng_start_reseed) n_start++;
      if (pif.prng_out_valid && pif.prng_out_ready) n_acc++;

      pop  = rnd_req && ev;
      push = pif.prng_out_valid && er;
      if (rnd_req && !ev) m_uf = 1;
      if (ph == P_RUN && rnd_req && !ev) m_stall++;
      m_done = (ph == P_WAIT_LO) && !pif.prng_busy;
      case (ph)
         P_IDLE: if (reseed_req) begin
            ph = P_START;
            m_seed = seed_in;
         end
         P_START: ph = P_WAIT_HI;
         P_WAIT_HI: if (pif.prng_busy) ph = P_WAIT_LO;
         P_WAIT_LO: if (!pif.prng_busy) begin
            ph = P_RUN;
            m_pops = 0;
         end
         default: begin
            if (pop) begin
               void'(mq.pop_front());
               m_pops++;
               m_words++;
            end
            if (push) begin
               mq.push_back(pif.prng_out_rnd);
               tag++;
            end
            if (trig) begin
               mq.delete();
               ph = P_START;
               m_seed = seed_in;
            end
         end
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      reseed_req = 0;
      rnd_req = 0;
      pif.prng_out_valid = 0;
      pif.prng_busy = 0;
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must drop at once.
   task automatic async_reset(input string w);
      #2;
      nrst = 0;
      #1;
      check_zero(w);
      model_reset();
      idle_inputs();
      @(negedge clk);
      #1;
      nrst = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic reseed_to_run(input int hi_cycles);
      reseed_req = 1;
      pif.prng_busy = 0;
      step();
      reseed_req = 0;
      step();
      pif.prng_busy = 1;
      repeat (hi_cycles) step();
      pif.prng_busy = 0;
      step();
   endtask

   task automatic rand_cycles(input int n, input int p_valid, input int p_req, input int p_rs);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 399) == 0) async_reset("rst_rand");
         pif.prng_out_valid = ($urandom_range(0, 99) < p_valid);
         rnd_req    = ($urandom_range(0, 99) < p_req);
         reseed_req = ($urandom_range(0, 99) < p_rs);
         seed_in    = {16'($urandom), $urandom, $urandom};
         drive_word();
         if (ph == P_START) begin
            b_lo = $urandom_range(0, 2);
            b_hi = $urandom_range(2, 6);
         end
         if (b_lo > 0) begin
            pif.prng_busy = 0;
            b_lo--;
         end else if (b_hi > 0) begin
            pif.prng_busy = 1;
            b_hi--;
         end else begin
            pif.prng_busy = 0;
         end
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tag = 1;
      n_start = 0;
      n_acc = 0;
      seed_in = '0;
      idle_inputs();
      pif.prng_out_rnd = '0;
      model_reset();
      nrst = 0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("rst0");
      @(negedge clk);
      nrst = 1;
      @(posedge clk);
      #1;

      // request before any reseed
      rnd_req = 1;
      step();
      rnd_req = 0;
      step();

      // first reseed with a fixed seed, busy high for 10 cycles
      seed_in = 80'h0123456789ABCDEF0123;
      n_start = 0;
      reseed_to_run(10);
      check_val("start_count", 128'(n_start), 128'(1));
      seed_in = 80'hFEDC_BA98_7654_3210_AAAA;

      // fill with no consumer: only DEPTH words are accepted
      pif.prng_out_valid = 1;
      n_acc = 0;
      for (int i = 0; i < 4; i++) begin
         drive_word();
         step();
      end
      check_val("fill_accept", 128'(n_acc), 128'(DEPTH));

      // continuous draining until the auto reseed, then through it
      rnd_req = 1;
      for (int i = 0; i < 8; i++) begin
         drive_word();
         step();
      end
      pif.prng_busy = 1;
      for (int i = 0; i < 3; i++) begin
         drive_word();
         step();
      end
      pif.prng_busy = 0;
      for (int i = 0; i < 8; i++) begin
         drive_word();
         step();
      end

      // bring the sequencer into WAIT_LO and reset there
      rnd_req = 0;
      pif.prng_out_valid = 0;
      for (int i = 0; i < 20 && ph != P_WAIT_LO; i++) begin
         reseed_req = (ph == P_RUN || ph == P_IDLE);
         pif.prng_busy = (ph == P_WAIT_HI);
         step();
      end
      check_val("reach_wait_lo", 128'(ph), 128'(P_WAIT_LO));
      reseed_req = 0;
      pif.prng_busy = 1;
      async_reset("rst_wait_lo");
      step();
      step();

      // reset with two words buffered
      reseed_to_run(3);
      pif.prng_out_valid = 1;
      for (int i = 0; i < 3; i++) begin
         drive_word();
         step();
      end
      pif.prng_out_valid = 0;
      async_reset("rst_run");
      step();
      step();

      // randomized traffic
      for (int r = 0; r < 6; r++) begin
         rand_cycles(350, $urandom_range(20, 100), $urandom_range(10, 90), 2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/prng_rnd_feeder.md
Name: prng_rnd_feeder

Overview:
- Consumer-side controller for the `prng_top` output stream in masked AES builds.
- Owns the reseed sequence: drives `prng_seed` and `prng_start_reseed`, then tracks `prng_busy`.
- Reads random words through the `prng_out_valid`/`prng_out_ready` handshake into a small FIFO.
- Presents one fresh word per consumer request to the masked AES core, replacing the free-running direct connection.

Parameters:
- RND, 1160, width of one random word (20*(rnd_busz+rnd_busb) for the default core).
- DEPTH, 2, FIFO entries; power of two, 2..8.
- RESEED_PERIOD, 0, words popped before an automatic reseed; 0 disables auto-reseed.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- seed_in  in  80  seed value used for every reseed
- reseed_req  in  1  request a reseed (level, sampled in IDLE/RUN)
- prng_seed  out  80  seed to PRNG, registered
- prng_start_reseed  out  1  one-cycle reseed start pulse
- prng_busy  in  1  PRNG busy
- prng_out_valid  in  1  PRNG word valid
- prng_out_ready  out  1  feeder accepts PRNG word
- prng_out_rnd  in  RND  PRNG word
- rnd_req  in  1  core consumes the head word this cycle
- rnd_valid  out  1  FIFO non-empty and state RUN
- rnd  out  RND  FIFO head word (registered storage, no PRNG-to-core combinational path)
- reseed_done  out  1  one-cycle pulse when reseed completes
- underflow  out  1  sticky; set when rnd_req arrives while rnd_valid=0

Behaviour:
- Reset (nrst=0, async):
  - state=IDLE; FIFO empty.
  - All outputs 0, including prng_seed, prng_out_ready, rnd_valid, rnd, reseed_done, underflow.
  - pop counter cleared.
  - A reset mid-reseed or mid-stream abandons everything; no pulse is emitted.
- States:
  - IDLE: wait for reseed_req=1, then go to START. The core cannot run before the first reseed.
  - START: one cycle.
    - Set prng_seed<=seed_in.
    - Assert prng_start_reseed=1.
    - Next state WAIT_HI.
  - WAIT_HI: wait for prng_busy=1, then go to WAIT_LO. If busy is already 1 in START, WAIT_HI still takes at least one cycle.
  - WAIT_LO: wait for prng_busy=0.
    - Then go to RUN.
    - Pulse reseed_done in the first RUN cycle.
    - Clear the pop counter.
  - RUN:
    - prng_out_ready = ~full, derived from the registered count only.
    - Push when prng_out_valid & prng_out_ready.
    - Pop when rnd_req & rnd_valid.
    - Push and pop may occur in the same cycle; count is unchanged.
    - Pointers wrap modulo DEPTH.
- Reseed from RUN:
  - Triggered by reseed_req=1, or by the pop counter reaching RESEED_PERIOD when nonzero.
  - In the trigger cycle, a pending pop completes; no push is accepted (prng_out_ready=0).
  - Next cycle: FIFO flushed (count=0), rnd_valid=0, state START.
  - Stale pre-reseed words are never delivered.
- Outside RUN:
  - prng_out_ready=0 and rnd_valid=0.
  - A rnd_req there sets underflow.
  - reseed_req in START/WAIT_* is ignored.
- Underflow:
  - rnd_req with rnd_valid=0 sets underflow, which clears only on reset.
  - FIFO state is unaffected.
- Pop counter:
  - 32-bit, increments per pop.
  - Compared with RESEED_PERIOD only when RESEED_PERIOD>0.

Optional Feature:
- Macro: RND_FEEDER_STATS_EN
- Defined:
  - Adds output stall_cnt [31:0], cleared on reset.
  - Increments, saturating at 0xFFFFFFFF, every RUN cycle with rnd_req=1 & rnd_valid=0.
  - Those cycles also set underflow.
  - Adds output word_cnt [31:0]: total pops since reset, saturating.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then reseed_req=1 for one cycle.
  - Expect prng_start_reseed high exactly one cycle, with prng_seed=seed_in (e.g. 80'h0123456789ABCDEF0123).
  - Hold busy high for 10 cycles, then low: expect reseed_done one cycle later and state RUN.
- Streaming:
  - RUN, DEPTH=2, prng_out_valid=1 constantly, rnd_req=0: expect exactly 2 words accepted, then prng_out_ready=0.
  - Then rnd_req=1 every cycle: words emerge in push order (tag words 1,2,3...) with no gaps after the first fill.
- Simultaneous push/pop, count=1: count stays 1; the head advances to the next tagged word.
- Auto-reseed:
  - RESEED_PERIOD=5: after the 5th pop, expect prng_out_ready=0 and FIFO flushed.
  - Expect the START pulse and rnd_valid=0 until reseed_done.
  - The first post-reseed word is the first PRNG word after busy falls.
- Underflow: rnd_req=1 in IDLE, or in RUN with FIFO empty, sets underflow and holds it through later traffic; with RND_FEEDER_STATS_EN, stall_cnt=number of such RUN cycles.
- Async reset: assert nrst=0 in WAIT_LO and in RUN with 2 words buffered; all outputs read 0 immediately; after release, state is IDLE.
